// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its consumers (instruction FIFO, decode).
//   DefaultXlen    : default PC / instruction width
//   DefaultResetPc : default first fetch address after reset
//   fetch_pkt_t    : packet pushed into the instruction FIFO, {pc, instr}
//   fetch_state_e  : fetch FSM states
package fetch_unit_pkg;

  localparam int unsigned DefaultXlen = 32;
  localparam logic [DefaultXlen-1:0] DefaultResetPc = 32'h0000_0000;

  typedef struct packed {
    logic [DefaultXlen-1:0] pc;
    logic [DefaultXlen-1:0] instr;
  } fetch_pkt_t;

  typedef enum logic {
    StIdle,
    StRun
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential instruction-memory reads, pairs each returned word
// with its PC and pushes {pc, instr} into a downstream FIFO. A one-entry hold register absorbs
// the single in-flight packet when the FIFO is full; redirects flush everything outstanding.
//   clk, rst_n        : clock, asynchronous active-low reset
//   fetch_en          : permits new memory requests
//   redirect_valid/pc : one-cycle flush and restart at redirect_pc (low two bits ignored)
//   imem_req/addr     : memory read request (combinational), address = fetch PC
//   imem_rdata        : read data, returned one cycle after an accepted request
//   fifo_full         : downstream FIFO full
//   fifo_write_en     : FIFO push strobe (combinational)
//   fifo_write_data   : {pc, instr}
//   instr_count       : packets pushed since reset, wrapping
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = DefaultXlen,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DefaultResetPc)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              fifo_full,
  output logic              fifo_write_en,
  output logic [2*XLEN-1:0] fifo_write_data,
  output logic [31:0]       instr_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_valid_q, inflight_valid_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [31:0]     instr_count_q, instr_count_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fetch_en) state_d = StRun;
      StRun:   if (!fetch_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // A new request is only issued when the hold register is empty and the FIFO has room, so
    // at most one packet is ever outstanding and a single hold entry is enough.
    imem_req      = (state_q == StRun) && fetch_en && !redirect_valid && !hold_valid_q &&
                    !fifo_full;
    imem_addr     = fetch_pc_q;
    fifo_write_en = (hold_valid_q || inflight_valid_q) && !fifo_full && !redirect_valid;
    fifo_write_data = hold_valid_q ? {hold_pc_q, hold_instr_q} : {inflight_pc_q, imem_rdata};
    instr_count   = instr_count_q;

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    // Read data is only valid for one cycle, so the in-flight slot always empties after a cycle.
    inflight_valid_d = imem_req;
    inflight_pc_d    = imem_req ? fetch_pc_q : inflight_pc_q;

    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if (redirect_valid) begin
      hold_valid_d = 1'b0;
    end else if (inflight_valid_q && fifo_full) begin
      hold_valid_d = 1'b1;
      hold_pc_d    = inflight_pc_q;
      hold_instr_d = imem_rdata;
    end else if (hold_valid_q && fifo_write_en) begin
      hold_valid_d = 1'b0;
    end

    instr_count_d = instr_count_q + 32'(fifo_write_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      fetch_pc_q       <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      hold_valid_q     <= 1'b0;
      hold_pc_q        <= '0;
      hold_instr_q     <= '0;
      instr_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      hold_valid_q     <= hold_valid_d;
      hold_pc_q        <= hold_pc_d;
      hold_instr_q     <= hold_instr_d;
      instr_count_q    <= instr_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. Main instance uses RESET_PC=0; a second instance with
// RESET_PC=FFFF_FFF8 covers address wrap. The reference model is a stream model: pushed PCs
// form a contiguous +4 sequence that restarts at the aligned redirect target, each instr
// equals pc ^ A5A5_0000, and instr_count equals the number of observed pushes.
module tb_fetch_unit;

  localparam logic [31:0] Key    = 32'hA5A5_0000;
  localparam logic [31:0] WrapPc = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fifo_full = 1'b0;

  logic        imem_req, w_imem_req;
  logic [31:0] imem_addr, w_imem_addr;
  logic [31:0] imem_rdata, w_imem_rdata;
  logic        fifo_write_en, w_fifo_write_en;
  logic [63:0] fifo_write_data, w_fifo_write_data;
  logic [31:0] instr_count, w_instr_count;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_cnt = '0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_write_data(fifo_write_data), .instr_count(instr_count)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(WrapPc)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(w_imem_rdata), .fifo_full(fifo_full), .fifo_write_en(w_fifo_write_en),
    .fifo_write_data(w_fifo_write_data), .instr_count(w_instr_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at addr is addr ^ Key, returned one cycle later.
  always @(posedge clk) begin
    imem_rdata   <= imem_addr ^ Key;
    w_imem_rdata <= w_imem_addr ^ Key;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Negedge sample: stream-model checks on the main instance, every cycle.
  task automatic sample();
    @(negedge clk);
    if (!rst_n) begin
      exp_pc  = 32'h0;
      exp_cnt = 32'h0;
    end else begin
      checks++;
      if (dut.hold_valid_q && dut.inflight_valid_q) begin
        failures++;
        $display("FAIL hold_and_inflight: both valid at %0t", $time);
      end
      checks++;
      if (imem_req && (fifo_full || redirect_valid || !fetch_en)) begin
        failures++;
        $display("FAIL req_gating: imem_req=1 full=%0b redir=%0b en=%0b", fifo_full,
                 redirect_valid, fetch_en);
      end
      checks++;
      if (instr_count !== exp_cnt) begin
        failures++;
        $display("FAIL instr_count: got %0d expected %0d", instr_count, exp_cnt);
      end
      if (redirect_valid) begin
        checks++;
        if (fifo_write_en !== 1'b0) begin
          failures++;
          $display("FAIL push_on_redirect: fifo_write_en=%b expected 0", fifo_write_en);
        end
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (fifo_write_en === 1'b1) begin
        checks++;
        if (fifo_write_data !== {exp_pc, exp_pc ^ Key}) begin
          failures++;
          $display("FAIL push_data: got %h expected %h", fifo_write_data, {exp_pc, exp_pc ^ Key});
        end
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || fifo_write_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b wen=%b expected 0 0", imem_req, fifo_write_en);
    end
    checks++;
    if (instr_count !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: count=%h addr=%h expected 0 0", instr_count, imem_addr);
    end
    checks++;
    if (w_imem_addr !== WrapPc) begin
      failures++;
      $display("FAIL reset_pc_param: got %h expected %h", w_imem_addr, WrapPc);
    end
    sample();
    step();
    sample();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    int first = -1;
    int pushes = 0;
    fetch_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (c == 0) begin
        checks++;
        if (imem_req !== 1'b0) begin
          failures++;
          $display("FAIL idle_no_req: imem_req=%b expected 0", imem_req);
        end
      end
      if (c == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          failures++;
          $display("FAIL first_req: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
      end
      if (fifo_write_en === 1'b1) begin
        if (first < 0) first = c;
        pushes++;
      end
      step();
    end
    checks++;
    if (first != 2 || pushes != 10) begin
      failures++;
      $display("FAIL free_run_timing: first=%0d pushes=%0d expected 2 10", first, pushes);
    end
    sample();
    checks++;
    if (instr_count !== 32'd10) begin
      failures++;
      $display("FAIL free_run_count: got %0d expected 10", instr_count);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] req_pc;
    sample();
    req_pc = imem_addr;
    step();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (fifo_write_en !== 1'b0 || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall: wen=%b req=%b expected 0 0", fifo_write_en, imem_req);
      end
      step();
    end
    fifo_full = 1'b0;
    sample();
    checks++;
    if (fifo_write_en !== 1'b1 || fifo_write_data[63:32] !== req_pc || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: wen=%b pc=%h req=%b expected 1 %h 0", fifo_write_en,
               fifo_write_data[63:32], imem_req, req_pc);
    end
    step();
    sample();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== req_pc + 32'd4) begin
      failures++;
      $display("FAIL bp_resume: req=%b addr=%h expected 1 %h", imem_req, imem_addr,
               req_pc + 32'd4);
    end
    step();
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    sample();
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_no_req: imem_req=%b expected 0", imem_req);
    end
    step();
    redirect_valid = 1'b0;
    sample();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL redir_target: req=%b addr=%h expected 1 00001000", imem_req, imem_addr);
    end
    step();
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++;
      if (fifo_write_en !== 1'b1 || fifo_write_data[63:32] !== 32'h1000 + 32'(4 * c)) begin
        failures++;
        $display("FAIL redir_stream: wen=%b pc=%h expected 1 %h", fifo_write_en,
                 fifo_write_data[63:32], 32'h1000 + 32'(4 * c));
      end
      step();
    end
  endtask

  task automatic test_redirect_hold();
    fifo_full = 1'b1;
    sample();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    sample();
    step();
    redirect_valid = 1'b0;
    sample();
    step();
    fifo_full = 1'b0;
    sample();
    checks++;
    if (fifo_write_en !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
      failures++;
      $display("FAIL redir_hold: wen=%b req=%b addr=%h expected 0 1 00002000", fifo_write_en,
               imem_req, imem_addr);
    end
    step();
    sample();
    checks++;
    if (fifo_write_en !== 1'b1 || fifo_write_data[63:32] !== 32'h0000_2000) begin
      failures++;
      $display("FAIL redir_hold_push: wen=%b pc=%h expected 1 00002000", fifo_write_en,
               fifo_write_data[63:32]);
    end
    step();
  endtask

  task automatic test_wrap_and_stop();
    logic [31:0] wrap_exp [4];
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    fetch_en = 1'b0;
    rst_n    = 1'b0;
    sample();
    step();
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) fetch_en = 1'b0;
      sample();
      if (c >= 2 && c <= 5) begin
        checks++;
        if (w_fifo_write_en !== 1'b1 ||
            w_fifo_write_data !== {wrap_exp[c-2], wrap_exp[c-2] ^ Key}) begin
          failures++;
          $display("FAIL wrap_push%0d: wen=%b data=%h expected 1 %h", c - 2, w_fifo_write_en,
                   w_fifo_write_data, {wrap_exp[c-2], wrap_exp[c-2] ^ Key});
        end
      end
      if (c >= 5) begin
        checks++;
        if (w_imem_req !== 1'b0 || (c == 6 && w_fifo_write_en !== 1'b0)) begin
          failures++;
          $display("FAIL stop_drain: req=%b wen=%b at cycle %0d", w_imem_req, w_fifo_write_en, c);
        end
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    fetch_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      step();
    end
    fifo_full = 1'b1;
    sample();
    step();
    fifo_full = 1'b0;
    #1;
    checks++;
    if (fifo_write_en !== 1'b1) begin
      failures++;
      $display("FAIL held_push_pending: wen=%b expected 1", fifo_write_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_write_en !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: wen=%b req=%b expected 0 0", fifo_write_en, imem_req);
    end
    sample();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10 && !found; c++) begin
      sample();
      if (fifo_write_en === 1'b1) begin
        found = 1'b1;
        checks++;
        if (fifo_write_data[63:32] !== 32'h0) begin
          failures++;
          $display("FAIL post_reset_pc: got %h expected 00000000", fifo_write_data[63:32]);
        end
      end
      step();
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL post_reset_timeout: no push within 10 cycles");
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      fetch_en       = ($urandom_range(0, 7) != 0);
      fifo_full      = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      sample();
      step();
    end
    fetch_en       = 1'b0;
    fifo_full      = 1'b0;
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      step();
    end
    sample();
    checks++;
    if (imem_req !== 1'b0 || fifo_write_en !== 1'b0) begin
      failures++;
      $display("FAIL random_drain: req=%b wen=%b expected 0 0", imem_req, fifo_write_en);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_redirect_hold();
    test_wrap_and_stop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_en  input  1  high allows new instruction-memory requests.
REQ-006 redirect_valid  input  1  one-cycle pulse; flush and restart at redirect_pc.
REQ-007 redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored and treated as 0.
REQ-008 imem_req  output  1  instruction-memory read request, combinational.
REQ-009 imem_addr  output  XLEN  request address, equal to fetch_pc.
REQ-010 imem_rdata  input  XLEN  read data, valid exactly one cycle after an accepted imem_req.
REQ-011 fifo_full  input  1  downstream instruction FIFO full.
REQ-012 fifo_write_en  output  1  push strobe to the FIFO, combinational.
REQ-013 fifo_write_data  output  2*XLEN  fetch_pkt_t {pc, instr}.
REQ-014 instr_count  output  32  number of packets pushed since reset, wrapping.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
- IDLE -> RUN when fetch_en=1.
- RUN -> IDLE when fetch_en=0.
REQ-016 imem_req SHALL be (state==RUN) && fetch_en && !redirect_valid && !hold_valid && !fifo_full.
REQ-017 Each asserted imem_req SHALL advance fetch_pc by 4 (modulo 2^XLEN; 0xFFFF_FFFC wraps to 0) and set inflight_valid and inflight_pc=fetch_pc for the next cycle.
REQ-018 The output packet SHALL be taken from the hold register when hold_valid=1, else from {inflight_pc, imem_rdata} when inflight_valid=1.
REQ-019 fifo_write_en SHALL be (hold_valid || inflight_valid) && !fifo_full && !redirect_valid.
REQ-020 When hold_valid=1 and inflight_valid=1 in the same cycle, the design SHALL treat it as an error; the bench SHALL assert that it never occurs.
REQ-021 When inflight_valid=1 and fifo_full=1, the packet SHALL be captured into the hold register (hold_valid<=1) and no data SHALL be lost.
REQ-022 The hold register SHALL clear on the cycle it is pushed.
REQ-023 The hold register SHALL have one entry; REQ-016 guarantees at most one outstanding packet.
REQ-024 When redirect_valid=1:
- fetch_pc SHALL load {redirect_pc[XLEN-1:2], 2'b00};
- inflight_valid and hold_valid SHALL clear;
- no push or request SHALL occur that cycle;
- the first request at the new PC SHALL occur the next cycle if otherwise allowed.
REQ-025 If redirect_valid=1 coincides with an in-flight or held packet, that packet SHALL be discarded, never pushed.
REQ-026 Dropping fetch_en SHALL stop new requests only; an in-flight or held packet SHALL still drain to the FIFO.
REQ-027 instr_count SHALL increment by 1 on every cycle with fifo_write_en=1 and wrap 0xFFFF_FFFF -> 0.
REQ-028 Steady-state throughput with fifo_full=0 SHALL be one packet per cycle, with latency of one cycle from request to push.

Reset
REQ-029 On rst_n=0, asynchronously:
- state=IDLE;
- fetch_pc=RESET_PC;
- inflight_valid=0, hold_valid=0;
- instr_count=0.
REQ-030 During and after reset, before the first edge, imem_req=0 and fifo_write_en=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and held packets.

Structure
REQ-032 A shared package SHALL define fetch_pkt_t (pc, instr of XLEN each), XLEN and RESET_PC defaults; the FIFO and decode stage SHALL import the same package.
REQ-033 No sub-module is required; the hold register and FSM SHALL be implemented inline.

Verification
REQ-034 Free run: reset, fetch_en=1, fifo_full=0, imem_rdata=addr^32'hA5A5_0000 -> pushes pc=0,4,8,... one per cycle; first push two cycles after fetch_en rises; instr_count=10 after 10 pushes.
REQ-035 Backpressure: raise fifo_full for 3 cycles while a request is in flight -> packet held; no requests while full; held packet pushed first when full drops; no gaps or duplicates in the PC sequence.
REQ-036 Redirect: redirect_valid with redirect_pc=32'h0000_1003 during flow -> in-flight packet dropped; next imem_addr=32'h0000_1000; pushes continue at 1000, 1004, ...
REQ-037 Redirect while holding: hold_valid=1, fifo_full=1, redirect pulse -> held packet never pushed; fetch resumes at the redirect target once full drops.
REQ-038 Wrap and stop: RESET_PC=32'hFFFF_FFF8 -> pushes FFFF_FFF8, FFFF_FFFC, 0000_0000; drop fetch_en -> exactly one further push, then imem_req=0.
REQ-039 Async reset mid-stream with hold_valid=1 -> fifo_write_en=0 immediately; after release the first push has pc=RESET_PC.
